// File: rtl/fpu_op_responder.sv
// fpu_op_responder: known-good FPU endpoint for the decode/execute/flush handshake.
// Compares computed locally, arithmetic results from a preload FIFO; FPU_RESP_JITTER_EN adds LFSR latency jitter.
module fpu_op_responder #(
   parameter int          LATENCY    = 4,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        decode_i,
   input  logic        execute_i,
   input  logic [7:0]  fpu_op_i,
   input  logic [1:0]  round_mode_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic        load_valid_i,
   input  logic [31:0] load_data_i,
   output logic        load_ready_o,
   output logic [31:0] fpu_result_o,
   output logic        valid_arith_o,
   output logic        cmp_flag_o,
   output logic        valid_cmp_o,
   output logic [11:0] fpcsr_o,
   output logic        busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(LATENCY + 4) + 1;
   typedef enum logic [1:0] {IDLE, DEC, BUSY, DONE} state_t;
   state_t state;
   logic [31:0] opa_q, opb_q;
   logic [7:0] op_q;
   logic [1:0] rm_q, rm_o;
   logic [CW-1:0] cnt, lat_load;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic fifo_ovf;
   logic ivf, zf, qnf, snf;
   logic is_cmp, is_arith, empty, full, finish, pop, push;
   logic a_nan, b_nan, nan, snan, eq, lt, gt, cmp_ord, cmp_res;
   logic [31:0] arith_res;
`ifdef FPU_RESP_JITTER_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk or posedge rst)
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign lat_load = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
   assign lat_load = CW'(LATENCY - 1);
`endif
   always_comb begin
      is_cmp    = op_q inside {[8'd8:8'd13]};
      is_arith  = op_q < 8'd6;
      empty     = count == '0;
      full      = count == (AW+1)'(FIFO_DEPTH);
      finish    = !flush_i && state == BUSY && cnt == '0;
      pop       = finish && is_arith && !empty;
      push      = load_valid_i && (!full || pop);
      arith_res = !is_arith ? 32'h0 : empty ? 32'h7FC00000 : mem[rd_ptr];
      a_nan     = (&opa_q[30:23]) && (|opa_q[22:0]);
      b_nan     = (&opb_q[30:23]) && (|opb_q[22:0]);
      nan       = a_nan || b_nan;
      snan      = (a_nan && !opa_q[22]) || (b_nan && !opb_q[22]);
      // signed zeros compare equal; otherwise sign-magnitude ordering
      eq        = (opa_q[30:0] == '0 && opb_q[30:0] == '0) || opa_q == opb_q;
      lt        = !eq && ((opa_q[31] != opb_q[31]) ? opa_q[31] :
                  opa_q[31] ? opa_q[30:0] > opb_q[30:0] : opa_q[30:0] < opb_q[30:0]);
      gt        = !eq && !lt;
      cmp_ord   = op_q[2:0] == 3'd0 ? eq :
                  op_q[2:0] == 3'd1 ? !eq :
                  op_q[2:0] == 3'd2 ? gt :
                  op_q[2:0] == 3'd3 ? (gt || eq) :
                  op_q[2:0] == 3'd4 ? lt : (lt || eq);
      cmp_res   = nan ? op_q[2:0] == 3'd1 : cmp_ord;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fifo_ovf <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (load_valid_i && full && !pop) fifo_ovf <= 1'b1;
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= load_data_i;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= IDLE;
         opa_q         <= '0;
         opb_q         <= '0;
         op_q          <= '0;
         rm_q          <= '0;
         cnt           <= '0;
         valid_arith_o <= 1'b0;
         valid_cmp_o   <= 1'b0;
         fpu_result_o  <= '0;
         cmp_flag_o    <= 1'b0;
         {ivf, zf, qnf, snf} <= '0;
         rm_o          <= '0;
      end else if (flush_i) begin
         state         <= IDLE;
         valid_arith_o <= 1'b0;
         valid_cmp_o   <= 1'b0;
         fpu_result_o  <= '0;
         cmp_flag_o    <= 1'b0;
         {ivf, zf, qnf, snf} <= '0;
         rm_o          <= '0;
      end else begin
         case (state)
            IDLE: if (decode_i) begin
               {opa_q, opb_q, op_q, rm_q} <= {opa_i, opb_i, fpu_op_i, round_mode_i};
               state <= DEC;
            end
            DEC: if (execute_i) begin
               cnt   <= lat_load;
               state <= BUSY;
            end else if (decode_i) begin
               {opa_q, opb_q, op_q, rm_q} <= {opa_i, opb_i, fpu_op_i, round_mode_i};
            end
            BUSY: if (cnt == '0) begin
               state         <= DONE;
               valid_arith_o <= !is_cmp;
               valid_cmp_o   <= is_cmp;
               fpu_result_o  <= is_cmp ? 32'h0 : arith_res;
               cmp_flag_o    <= is_cmp && cmp_res;
               ivf           <= is_cmp ? nan : (!is_arith || empty);
               qnf           <= !is_cmp && is_arith && empty;
               snf           <= is_cmp && snan;
               zf            <= !is_cmp && arith_res[30:0] == '0;
               rm_o          <= rm_q;
            end else begin
               cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   assign load_ready_o = !full;
   assign busy_o       = state != IDLE;
   assign fpcsr_o      = {2'b00, ivf, 1'b0, zf, qnf, snf, 2'b00, rm_o, 1'b0};
endmodule

// File: tb/tb_fpu_op_responder.sv
// tb_fpu_op_responder: directed vector table plus hand-written FIFO, flush and handshake sequences.
module tb_fpu_op_responder;
   logic clk = 0, rst = 1, flush_i = 0, decode_i = 0, execute_i = 0;
   logic [7:0] fpu_op_i = 0;
   logic [1:0] round_mode_i = 0;
   logic [31:0] opa_i = 0, opb_i = 0, load_data_i = 0;
   logic load_valid_i = 0;
   logic load_ready_o, valid_arith_o, cmp_flag_o, valid_cmp_o, busy_o;
   logic [31:0] fpu_result_o;
   logic [11:0] fpcsr_o;
   int checks = 0, errors = 0;
   fpu_op_responder dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .decode_i(decode_i), .execute_i(execute_i),
      .fpu_op_i(fpu_op_i), .round_mode_i(round_mode_i), .opa_i(opa_i), .opb_i(opb_i),
      .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
      .fpu_result_o(fpu_result_o), .valid_arith_o(valid_arith_o), .cmp_flag_o(cmp_flag_o),
      .valid_cmp_o(valid_cmp_o), .fpcsr_o(fpcsr_o), .busy_o(busy_o)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0] op; logic [31:0] a, b; logic [1:0] rm; logic pre; logic [31:0] pre_d;
      logic [31:0] res; logic cmp, va, vc; logic [11:0] csr;
   } vec_t;
   vec_t v[14];
   task automatic step(); @(posedge clk); #1; endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic push(input logic [31:0] d);
      load_valid_i = 1; load_data_i = d; step(); load_valid_i = 0;
   endtask
   task automatic flush();
      flush_i = 1; step(); flush_i = 0;
   endtask
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!(valid_arith_o || valid_cmp_o) && lat < 20) begin step(); lat++; end
   endtask
   task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, output int lat);
      decode_i = 1; fpu_op_i = op; opa_i = a; opb_i = b; round_mode_i = rm;
      step(); decode_i = 0; execute_i = 1;
      step(); execute_i = 0;
      wait_valid(lat);
   endtask
   initial begin
      int lat;
      logic seen;
      v[0]  = '{8'd0,   32'h3F800000, 32'h40000000, 2'd2, 1, 32'h3F800000, 32'h3F800000, 0, 1, 0, 12'h004};
      v[1]  = '{8'd8,   32'h00000000, 32'h80000000, 2'd0, 0, 32'h0, 32'h0, 1, 0, 1, 12'h000};
      v[2]  = '{8'd12,  32'h7FA00000, 32'h3F800000, 2'd0, 0, 32'h0, 32'h0, 0, 0, 1, 12'h220};
      v[3]  = '{8'd1,   32'h3F800000, 32'h3F800000, 2'd1, 0, 32'h0, 32'h7FC00000, 0, 1, 0, 12'h242};
      v[4]  = '{8'd9,   32'h00000000, 32'h7FC00000, 2'd0, 0, 32'h0, 32'h0, 1, 0, 1, 12'h200};
      v[5]  = '{8'd10,  32'h3F800000, 32'hBF800000, 2'd0, 0, 32'h0, 32'h0, 1, 0, 1, 12'h000};
      v[6]  = '{8'd12,  32'hC0000000, 32'hBF800000, 2'd0, 0, 32'h0, 32'h0, 1, 0, 1, 12'h000};
      v[7]  = '{8'd13,  32'h40000000, 32'h40000000, 2'd3, 0, 32'h0, 32'h0, 1, 0, 1, 12'h006};
      v[8]  = '{8'd11,  32'h3F800000, 32'h40000000, 2'd0, 0, 32'h0, 32'h0, 0, 0, 1, 12'h000};
      v[9]  = '{8'd6,   32'h3F800000, 32'h40000000, 2'd0, 0, 32'h0, 32'h0, 0, 1, 0, 12'h280};
      v[10] = '{8'd14,  32'h3F800000, 32'h40000000, 2'd1, 0, 32'h0, 32'h0, 0, 1, 0, 12'h282};
      v[11] = '{8'd200, 32'h00000000, 32'h00000000, 2'd0, 0, 32'h0, 32'h0, 0, 1, 0, 12'h280};
      v[12] = '{8'd2,   32'h3F800000, 32'h40000000, 2'd0, 1, 32'h80000000, 32'h80000000, 0, 1, 0, 12'h080};
      v[13] = '{8'd10,  32'h7F800000, 32'h7F7FFFFF, 2'd0, 0, 32'h0, 32'h0, 1, 0, 1, 12'h000};
      repeat (3) step();
      chk("rst_result", fpu_result_o, 0);
      chk("rst_valids", {valid_arith_o, valid_cmp_o, cmp_flag_o, busy_o}, 0);
      chk("rst_fpcsr", fpcsr_o, 0);
      chk("rst_ready", load_ready_o, 1);
      rst = 0; step();
      chk("post_rst_busy", busy_o, 0);
      for (int i = 0; i < 14; i++) begin
         if (v[i].pre) push(v[i].pre_d);
         run_op(v[i].op, v[i].a, v[i].b, v[i].rm, lat);
         chk($sformatf("v%0d_latency", i), lat, 4);
         chk($sformatf("v%0d_result", i), fpu_result_o, v[i].res);
         chk($sformatf("v%0d_cmp", i), cmp_flag_o, v[i].cmp);
         chk($sformatf("v%0d_varith", i), valid_arith_o, v[i].va);
         chk($sformatf("v%0d_vcmp", i), valid_cmp_o, v[i].vc);
         chk($sformatf("v%0d_fpcsr", i), fpcsr_o, v[i].csr);
         step();
         chk($sformatf("v%0d_hold", i), {fpu_result_o, valid_arith_o, valid_cmp_o, busy_o},
             {v[i].res, v[i].va, v[i].vc, 1'b1});
         flush();
         chk($sformatf("v%0d_flush", i), {fpu_result_o, valid_arith_o, valid_cmp_o, cmp_flag_o, busy_o}, 0);
         chk($sformatf("v%0d_flush_fpcsr", i), fpcsr_o, 0);
      end
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("fill_ready%0d", i), load_ready_o, i < 8);
         push(32'(i + 1));
      end
      chk("fill_ready_full", load_ready_o, 0);
      chk("fill_overflow", dut.fifo_ovf, 1);
      run_op(8'd7, 32'h0, 32'h0, 2'd0, lat);
      chk("badop_result", {fpu_result_o, fpcsr_o}, {32'h0, 12'h280});
      flush();
      chk("badop_nopop", load_ready_o, 0);
      for (int i = 0; i < 8; i++) begin
         run_op(8'd3, 32'h0, 32'h0, 2'd0, lat);
         chk($sformatf("drain%0d", i), fpu_result_o, 32'(i + 1));
         flush();
      end
      chk("drain_ready", load_ready_o, 1);
      push(32'hAAAA5555);
      decode_i = 1; fpu_op_i = 0; opa_i = 0; opb_i = 0; round_mode_i = 0;
      step(); decode_i = 0; execute_i = 1;
      step(); execute_i = 0;
      step(); step();
      flush();
      chk("midflush_idle", {busy_o, valid_arith_o, valid_cmp_o}, 0);
      seen = 0;
      repeat (6) begin step(); seen |= valid_arith_o | valid_cmp_o | busy_o; end
      chk("midflush_novalid", seen, 0);
      run_op(8'd0, 32'h0, 32'h0, 2'd0, lat);
      chk("midflush_nopop", fpu_result_o, 32'hAAAA5555);
      flush();
      decode_i = 1; execute_i = 1; fpu_op_i = 8'd8; opa_i = 32'h80000000; opb_i = 32'h0;
      step(); decode_i = 0; execute_i = 0;
      seen = 0;
      repeat (6) begin step(); seen |= valid_arith_o | valid_cmp_o; end
      chk("decexec_wait", {seen, busy_o}, 2'b01);
      execute_i = 1; step(); execute_i = 0;
      wait_valid(lat);
      chk("decexec_latency", lat, 4);
      chk("decexec_cmp", {valid_cmp_o, cmp_flag_o}, 2'b11);
      flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
